// File: rtl/mips_pkg.sv
// Shared pipeline definitions for the register-file write path.
// Contents: register/data widths, the hardwired-zero register address and the
// write-request struct {en, addr, data} that drives the register-file port.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

endpackage

// File: rtl/id_ll_result_fifo.sv
// Synchronous FIFO buffering long-latency results until the write port is free.
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   push_i / wdata_i    enqueue request and payload (ignored when full)
//   pop_i               dequeue request (ignored when empty)
//   rdata_o             head entry, valid whenever empty_o is low
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries
module id_ll_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/id_regwrite_arbiter.sv
// Register-file write-port owner shared by the WB stage and a long-latency unit.
// WB always wins the port; buffered long-latency results drain when WB is idle
// (or writing $0). A per-register busy scoreboard holds ID on hazards against
// results that are still in flight.
// Ports:
//   Clk, Reset                          clock, synchronous active-high reset
//   RegWrite_WB/Write_Register_WB/Write_Data_WB   WB write request
//   Read_Address_1_ID/Read_Address_2_ID ID source registers
//   RegWrite_ID/Dest_ID                 ID in-pipeline destination
//   LL_Issue_ID/LL_Dest_ID              ID issue of a long-latency op
//   LL_Valid/LL_Dest/LL_Data/LL_Ready   long-latency result handshake
//   Stall_ID                            hold ID/IF this cycle
//   RF_Write_En/Addr/Data               register-file write port
//   Queue_Count                         result FIFO occupancy
module id_regwrite_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     RegWrite_WB,
  input  logic [ADDR_W-1:0]        Write_Register_WB,
  input  logic [DATA_W-1:0]        Write_Data_WB,
  input  logic [ADDR_W-1:0]        Read_Address_1_ID,
  input  logic [ADDR_W-1:0]        Read_Address_2_ID,
  input  logic                     RegWrite_ID,
  input  logic [ADDR_W-1:0]        Dest_ID,
  input  logic                     LL_Issue_ID,
  input  logic [ADDR_W-1:0]        LL_Dest_ID,
  input  logic                     LL_Valid,
  input  logic [ADDR_W-1:0]        LL_Dest,
  input  logic [DATA_W-1:0]        LL_Data,
  output logic                     LL_Ready,
  output logic                     Stall_ID,
  output logic                     RF_Write_En,
  output logic [ADDR_W-1:0]        RF_Write_Addr,
  output logic [DATA_W-1:0]        RF_Write_Data,
  output logic [$clog2(DEPTH):0]   Queue_Count
);

  import mips_pkg::*;

  localparam int NREG = 1 << ADDR_W;
  localparam int CW   = ADDR_W + 1;

  logic [NREG-1:0]          busy_q, busy_d;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [ADDR_W-1:0]        head_addr;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop, wb_act, issue;
  logic [CW-1:0]            busy_cnt;
  logic                     credit_out;
  wr_req_t                  rf_req;

  assign LL_Ready  = !Reset && !fifo_full;
  // $0 results are acknowledged but never stored.
  assign push      = LL_Valid && LL_Ready && (LL_Dest != REG_ZERO);
  assign wb_act    = RegWrite_WB && (Write_Register_WB != REG_ZERO);
  assign pop       = !Reset && !wb_act && !fifo_empty;
  assign head_addr = head[ADDR_W+DATA_W-1:DATA_W];

  id_ll_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .push_i  (push),
    .wdata_i ({LL_Dest, LL_Data}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (Queue_Count)
  );

  always_comb begin
    rf_req = '0;
    if (!Reset) begin
      if (wb_act) begin
        rf_req.en   = 1'b1;
        rf_req.addr = Write_Register_WB;
        rf_req.data = Write_Data_WB;
      end else if (!fifo_empty) begin
        rf_req.en   = 1'b1;
        rf_req.addr = head_addr;
        rf_req.data = head[DATA_W-1:0];
      end
    end
  end

  assign RF_Write_En   = rf_req.en;
  assign RF_Write_Addr = rf_req.addr;
  assign RF_Write_Data = rf_req.data;

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NREG; i++) busy_cnt = busy_cnt + CW'(busy_q[i]);
  end

  // Every busy register owns either a FIFO slot or a result still inside the
  // unit; once the FIFO is full and those cover DEPTH, a new issue could
  // produce a result with nowhere to land.
  assign credit_out = fifo_full && (busy_cnt >= CW'(DEPTH));

  always_comb begin
    Stall_ID = 1'b0;
    if (!Reset) begin
      Stall_ID = busy_q[Read_Address_1_ID] || busy_q[Read_Address_2_ID] ||
                 (RegWrite_ID && busy_q[Dest_ID]) ||
                 (LL_Issue_ID && (busy_q[LL_Dest_ID] || credit_out));
    end
  end

  assign issue = LL_Issue_ID && !Stall_ID && (LL_Dest_ID != REG_ZERO);

  // Clear applied before set so a same-cycle issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (pop)   busy_d[head_addr]  = 1'b0;
    if (issue) busy_d[LL_Dest_ID] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: tb/tb_id_regwrite_arbiter.sv
module tb_id_regwrite_arbiter;

  logic        Clk;
  logic        Reset;
  logic        RegWrite_WB;
  logic [4:0]  Write_Register_WB;
  logic [31:0] Write_Data_WB;
  logic [4:0]  Read_Address_1_ID, Read_Address_2_ID;
  logic        RegWrite_ID;
  logic [4:0]  Dest_ID;
  logic        LL_Issue_ID;
  logic [4:0]  LL_Dest_ID;
  logic        LL_Valid;
  logic [4:0]  LL_Dest;
  logic [31:0] LL_Data;
  logic        LL_Ready, Stall_ID, RF_Write_En;
  logic [4:0]  RF_Write_Addr;
  logic [31:0] RF_Write_Data;
  logic [1:0]  Queue_Count;

  int n_assert = 0;
  int n_fail   = 0;

  id_regwrite_arbiter #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .RegWrite_WB       (RegWrite_WB),
    .Write_Register_WB (Write_Register_WB),
    .Write_Data_WB     (Write_Data_WB),
    .Read_Address_1_ID (Read_Address_1_ID),
    .Read_Address_2_ID (Read_Address_2_ID),
    .RegWrite_ID       (RegWrite_ID),
    .Dest_ID           (Dest_ID),
    .LL_Issue_ID       (LL_Issue_ID),
    .LL_Dest_ID        (LL_Dest_ID),
    .LL_Valid          (LL_Valid),
    .LL_Dest           (LL_Dest),
    .LL_Data           (LL_Data),
    .LL_Ready          (LL_Ready),
    .Stall_ID          (Stall_ID),
    .RF_Write_En       (RF_Write_En),
    .RF_Write_Addr     (RF_Write_Addr),
    .RF_Write_Data     (RF_Write_Data),
    .Queue_Count       (Queue_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; checks happen before the next edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic port(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".en"}, RF_Write_En, en);
    if (en) begin
      chk({tag, ".addr"}, RF_Write_Addr, a);
      chk({tag, ".data"}, RF_Write_Data, d);
    end
  endtask

  initial begin
    Reset = 1; RegWrite_WB = 0; Write_Register_WB = 0; Write_Data_WB = 0;
    Read_Address_1_ID = 0; Read_Address_2_ID = 0; RegWrite_ID = 0; Dest_ID = 0;
    LL_Issue_ID = 0; LL_Dest_ID = 0; LL_Valid = 0; LL_Dest = 0; LL_Data = 0;

    // 1: reset then release
    tick(); tick();
    chk("rst.ready", LL_Ready, 0);
    chk("rst.wen", RF_Write_En, 0);
    chk("rst.addr", RF_Write_Addr, 0);
    Reset = 0; #1;
    chk("init.qc", Queue_Count, 0);
    chk("init.ready", LL_Ready, 1);
    chk("init.stall", Stall_ID, 0);
    chk("init.wen", RF_Write_En, 0);

    // 2: issue to $8, RAW stall until write-back
    LL_Issue_ID = 1; LL_Dest_ID = 8; #1;
    chk("t2.issue_stall", Stall_ID, 0);
    tick();
    LL_Issue_ID = 0; Read_Address_1_ID = 8; #1;
    chk("t2.raw_stall", Stall_ID, 1);
    LL_Valid = 1; LL_Dest = 8; LL_Data = 32'hDEADBEEF; #1;
    chk("t2.ready", LL_Ready, 1);
    chk("t2.no_writethrough", RF_Write_En, 0);
    tick();
    LL_Valid = 0; #1;
    chk("t2.qc", Queue_Count, 1);
    port("t2.drain", 1, 8, 32'hDEADBEEF);
    chk("t2.stall_during_write", Stall_ID, 1);
    tick();
    chk("t2.stall_released", Stall_ID, 0);
    chk("t2.idle", RF_Write_En, 0);
    chk("t2.qc0", Queue_Count, 0);
    Read_Address_1_ID = 0;

    // 3: WB priority over buffered $9
    LL_Valid = 1; LL_Dest = 9; LL_Data = 32'h11;
    tick();
    LL_Valid = 0; RegWrite_WB = 1; Write_Register_WB = 3; Write_Data_WB = 32'h22; #1;
    for (int i = 0; i < 3; i++) begin
      port("t3.wb", 1, 3, 32'h22);
      chk("t3.qc", Queue_Count, 1);
      tick();
    end
    RegWrite_WB = 0; #1;
    port("t3.head", 1, 9, 32'h11);
    chk("t3.qc_drain", Queue_Count, 1);
    tick();
    chk("t3.qc_after", Queue_Count, 0);

    // 4: fill while WB busy; third result held until space
    RegWrite_WB = 1; Write_Register_WB = 3; Write_Data_WB = 32'h22;
    LL_Valid = 1; LL_Dest = 4; LL_Data = 32'h44;
    tick();
    LL_Dest = 5; LL_Data = 32'h55;
    tick();
    LL_Dest = 6; LL_Data = 32'h66; #1;
    chk("t4.qc_full", Queue_Count, 2);
    chk("t4.ready_full", LL_Ready, 0);
    tick();
    chk("t4.held_qc", Queue_Count, 2);
    RegWrite_WB = 0; #1;
    chk("t4.ready_pop1", LL_Ready, 0);
    port("t4.pop4", 1, 4, 32'h44);
    tick();
    chk("t4.qc_after_pop", Queue_Count, 1);
    chk("t4.ready_again", LL_Ready, 1);
    port("t4.pop5", 1, 5, 32'h55);
    tick();
    LL_Valid = 0; #1;
    chk("t4.qc_pushpop", Queue_Count, 1);
    port("t4.pop6", 1, 6, 32'h66);
    tick();
    chk("t4.qc_empty", Queue_Count, 0);

    // 5: $0 result dropped, WB $0 treated as idle
    LL_Valid = 1; LL_Dest = 0; LL_Data = 32'h77;
    RegWrite_WB = 1; Write_Register_WB = 0; Write_Data_WB = 32'h99; #1;
    chk("t5.ready", LL_Ready, 1);
    chk("t5.wb0_idle", RF_Write_En, 0);
    tick();
    chk("t5.qc_drop", Queue_Count, 0);
    chk("t5.no_write", RF_Write_En, 0);
    LL_Dest = 10; LL_Data = 32'hAA;
    tick();
    LL_Valid = 0; #1;
    chk("t5.qc1", Queue_Count, 1);
    port("t5.drain_past_wb0", 1, 10, 32'hAA);
    tick();
    chk("t5.qc0", Queue_Count, 0);
    RegWrite_WB = 0;

    // 6: reset mid-operation
    LL_Issue_ID = 1; LL_Dest_ID = 7;
    tick();
    LL_Issue_ID = 0; RegWrite_WB = 1; Write_Register_WB = 3;
    LL_Valid = 1; LL_Dest = 12; LL_Data = 32'h12;
    tick();
    LL_Valid = 0; Read_Address_1_ID = 7; #1;
    chk("t6.qc1", Queue_Count, 1);
    chk("t6.stall7", Stall_ID, 1);
    Reset = 1; #1;
    chk("t6.rst_stall", Stall_ID, 0);
    chk("t6.rst_wen", RF_Write_En, 0);
    chk("t6.rst_ready", LL_Ready, 0);
    tick();
    Reset = 0; #1;
    chk("t6.qc0", Queue_Count, 0);
    chk("t6.stall7_clr", Stall_ID, 0);
    chk("t6.wen_wb", RF_Write_En, 1);
    Read_Address_1_ID = 0;

    // 7: WAW, source-2 RAW, issue credit, ignored issue, set-wins
    RegWrite_WB = 0;
    LL_Issue_ID = 1; LL_Dest_ID = 20;
    tick();
    LL_Dest_ID = 21;
    tick();
    LL_Issue_ID = 0; RegWrite_ID = 1; Dest_ID = 20; #1;
    chk("t7.waw", Stall_ID, 1);
    RegWrite_ID = 0; Read_Address_2_ID = 21; #1;
    chk("t7.raw2", Stall_ID, 1);
    Read_Address_2_ID = 0; #1;
    chk("t7.no_hazard", Stall_ID, 0);
    RegWrite_WB = 1; Write_Register_WB = 3;
    LL_Valid = 1; LL_Dest = 22; LL_Data = 32'h2222;
    tick();
    LL_Dest = 23; LL_Data = 32'h2323;
    tick();
    LL_Valid = 0; LL_Issue_ID = 1; LL_Dest_ID = 24; #1;
    chk("t7.credit_stall", Stall_ID, 1);
    tick();
    LL_Issue_ID = 0; Read_Address_1_ID = 24; #1;
    chk("t7.ignored_issue", Stall_ID, 0);
    Read_Address_1_ID = 0; RegWrite_WB = 0; #1;
    port("t7.pop22", 1, 22, 32'h2222);
    tick();
    LL_Issue_ID = 1; LL_Dest_ID = 23; #1;
    chk("t7.issue23_ok", Stall_ID, 0);
    port("t7.pop23", 1, 23, 32'h2323);
    tick();
    LL_Issue_ID = 0; Read_Address_1_ID = 23; #1;
    chk("t7.set_wins", Stall_ID, 1);
    chk("t7.qc0", Queue_Count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
